// File: rtl/seller1_vending_fsm.sv
// seller1_vending_fsm: single-drink vending controller, price 1.5 yuan.
// Credit and change are counted in half-yuan units (price = 3 units).
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   d1    - 0.5-yuan coin pulse (1 unit)
//   d2    - 1-yuan coin pulse   (2 units)
//   d3    - 2-yuan coin pulse   (4 units)
//   out1  - registered one-cycle dispense pulse
//   out2  - registered change in half-yuan units, nonzero only with out1
//   err   - registered illegal-input flag (only with SELLER1_ERR_EN)
//
// Build option: define SELLER1_ERR_EN to add the err output.

module seller1_vending_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    output logic       out1,
    output logic [1:0] out2
`ifdef SELLER1_ERR_EN
    ,
    output logic       err
`endif
);

    // State encoding equals the held credit in half-yuan units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        ONE  = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] coin_val;
    logic       coin_ok;
    logic       coin_bad;
    logic [2:0] total;
    logic       pay;

    // One-hot check on the coin lines.
    always_comb begin
        coin_val = 3'd0;
        coin_ok  = 1'b0;
        coin_bad = 1'b0;
        case ({d3, d2, d1})
            3'b000: begin
                coin_val = 3'd0;
            end
            3'b001: begin
                coin_val = 3'd1;
                coin_ok  = 1'b1;
            end
            3'b010: begin
                coin_val = 3'd2;
                coin_ok  = 1'b1;
            end
            3'b100: begin
                coin_val = 3'd4;
                coin_ok  = 1'b1;
            end
            default: begin
                coin_bad = 1'b1;
            end
        endcase
    end

    // Credit 0..2 plus coin 1..4 stays within 3 bits (max 6).
    always_comb begin
        total = {1'b0, state} + coin_val;
        pay   = (total >= 3'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out1  <= 1'b0;
            out2  <= 2'd0;
        end else begin
            out1 <= 1'b0;
            out2 <= 2'd0;
            if (coin_ok) begin
                if (pay) begin
                    out1  <= 1'b1;
                    // total is 3..6 here; total-3 == total[1:0]+1 mod 4.
                    out2  <= total[1:0] + 2'd1;
                    state <= IDLE;
                end else begin
                    unique case (total[1:0])
                        2'd1:    state <= HALF;
                        2'd2:    state <= ONE;
                        default: state <= IDLE;
                    endcase
                end
            end else if (state == state_t'(2'd3)) begin
                // Unreachable encoding: recover to a clean state.
                state <= IDLE;
            end
        end
    end

`ifdef SELLER1_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= coin_bad;
        end
    end
`else
    // Illegal inputs are dropped silently in this build.
    logic unused_bad;
    assign unused_bad = coin_bad;
`endif

endmodule

// File: tb/tb_seller1_vending_fsm.sv
// Scoreboard bench for seller1_vending_fsm.
// Directed coin vectors; expected outputs queued, checked by a monitor.

module tb_seller1_vending_fsm;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       d2;
    logic       d3;
    logic       out1;
    logic [1:0] out2;
`ifdef SELLER1_ERR_EN
    logic       err;
`endif

    seller1_vending_fsm dut (
        .clk  (clk),
        .rst  (rst),
        .d1   (d1),
        .d2   (d2),
        .d3   (d3),
        .out1 (out1),
        .out2 (out2)
`ifdef SELLER1_ERR_EN
        ,
        .err  (err)
`endif
    );

    typedef struct packed {
        int         idx;
        logic       o1;
        logic [1:0] o2;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;
    int   n_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input and queue the output expected after the edge.
    task automatic step(input logic r, input logic [2:0] c,
                        input logic e1, input logic [1:0] e2,
                        input logic ee);
        exp_t e;
        @(negedge clk);
        rst = r;
        {d3, d2, d1} = c;
        e.idx = n_vec;
        e.o1  = e1;
        e.o2  = e2;
        e.er  = ee;
        q.push_back(e);
        n_vec++;
    endtask

    // Monitor: one queued expectation per sampled edge.
    initial begin
        exp_t e;
        logic ae;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
`ifdef SELLER1_ERR_EN
                ae = err;
`else
                ae = e.er;
`endif
                n_cmp++;
                if (out1 !== e.o1 || out2 !== e.o2 || ae !== e.er) begin
                    n_bad++;
                    $display("FAIL vec%0d out1/out2/err got %b/%0d/%b want %b/%0d/%b",
                             e.idx, out1, out2, ae, e.o1, e.o2, e.er);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_vec = 0;
        rst = 1'b1;
        d1 = 1'b0;
        d2 = 1'b0;
        d3 = 1'b0;
        // reset 2 cycles, then idle
        step(1, 3'b000, 0, 0, 0);
        step(1, 3'b000, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        // d1, d2 -> dispense, change 0
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b010, 1, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        // d1, d1, d3 -> change 3
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        step(0, 3'b100, 1, 3, 0);
        step(0, 3'b000, 0, 0, 0);
        // d3 from idle -> change 1; d1, d3 -> change 2
        step(0, 3'b100, 1, 1, 0);
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b100, 1, 2, 0);
        step(0, 3'b000, 0, 0, 0);
        // d2, d2 -> change 1
        step(0, 3'b010, 0, 0, 0);
        step(0, 3'b010, 1, 1, 0);
        step(0, 3'b000, 0, 0, 0);
        // lone d2, reset, d1 -> HALF; then d2 dispenses change 0
        step(0, 3'b010, 0, 0, 0);
        step(1, 3'b000, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        step(0, 3'b010, 1, 0, 0);
        // illegal from idle: no change, err pulse
        step(0, 3'b011, 0, 0, 1);
        step(0, 3'b000, 0, 0, 0);
        step(0, 3'b010, 0, 0, 0);
        step(0, 3'b001, 1, 0, 0);
        // illegal with HALF credit, then d2 -> change 0
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b110, 0, 0, 1);
        step(0, 3'b111, 0, 0, 1);
        step(0, 3'b010, 1, 0, 0);
        // back-to-back purchases
        step(0, 3'b100, 1, 1, 0);
        step(0, 3'b100, 1, 1, 0);
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b010, 1, 0, 0);
        // ONE + d3 -> change 3 directly after reaching ONE
        step(0, 3'b010, 0, 0, 0);
        step(0, 3'b100, 1, 3, 0);
        // reset wins over a completing coin
        step(0, 3'b010, 0, 0, 0);
        step(1, 3'b010, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b001, 1, 0, 0);
        step(0, 3'b000, 0, 0, 0);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        if (n_cmp != n_vec) begin
            n_bad++;
            $display("FAIL count compared got %0d want %0d", n_cmp, n_vec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seller1_vending_fsm.md
Name: seller1_vending_fsm

Overview:
Single-drink vending-machine controller. It accepts three coin denominations (0.5, 1 and 2 yuan) as single-cycle pulses and accumulates credit. When credit reaches the drink price of 1.5 yuan, it dispenses one drink and returns change. It sits between the coin-acceptor front end, which debounces the coins and produces the pulses, and the dispenser/change actuators.

Parameters:
None. The price is fixed at 1.5 yuan, which is 3 half-yuan units. All internal money arithmetic is in half-yuan units.

Ports:
clk  input  1  system clock; all logic is rising-edge triggered
rst  input  1  reset; synchronous, active-high
d1  input  1  0.5-yuan coin pulse, one cycle wide
d2  input  1  1-yuan coin pulse, one cycle wide
d3  input  1  2-yuan coin pulse, one cycle wide
out1  output  1  drink-dispense pulse, one cycle wide
out2  output  2  change amount in half-yuan units (0 to 3), valid while out1=1, otherwise 0
err  output  1  present only when SELLER1_ERR_EN is defined (see Optional Feature)

Behaviour:
- Coin value in half-yuan units: d1=1, d2=2, d3=4.
- Exactly one of d1/d2/d3 high in a cycle = valid coin.
- All of d1/d2/d3 low = no coin.
- Two or more of d1/d2/d3 high in the same cycle = illegal. An illegal cycle is treated as no coin: credit is unchanged and no output pulse is produced.
- FSM states hold the credit:
  - IDLE = 0
  - HALF = 1 (0.5 yuan)
  - ONE = 2 (1 yuan)
- On each rising clk edge with rst=1:
  - state <= IDLE
  - out1 <= 0
  - out2 <= 0
- On each rising clk edge with rst=0 and a valid coin, compute total = credit + coin value (range 1 to 6):
  - total >= 3: out1 <= 1, out2 <= total - 3, state <= IDLE.
  - total < 3: state <= credit state for total (HALF or ONE), out1 <= 0, out2 <= 0.
- On each rising clk edge with no coin or an illegal coin: out1 <= 0, out2 <= 0, state held.
- Resulting transitions:
  - IDLE: d1 -> HALF; d2 -> ONE; d3 -> dispense with change 1.
  - HALF: d1 -> ONE; d2 -> dispense with change 0; d3 -> dispense with change 2.
  - ONE: d1 -> dispense with change 0; d2 -> dispense with change 1; d3 -> dispense with change 3.
- Latency: outputs are registered. out1/out2 assert in the cycle after the edge that sampled the completing coin, and stay asserted for exactly one cycle.
- A coin sampled in the same cycle that out1 is high is accumulated from IDLE, so back-to-back purchases are supported.
- Credit is held indefinitely between coins; there is no timeout.
- Reset mid-operation discards accumulated credit without dispensing, and clears any pending out1/out2 on that edge.
- out2 never exceeds 3, and out2 is 0 whenever out1 is 0.

Optional Feature:
SELLER1_ERR_EN
- Defined: adds output err (1 bit, registered, reset 0).
  - err <= 1 for one cycle after any edge that sampled an illegal multi-coin input; otherwise err <= 0.
  - The FSM still ignores the illegal coin.
- Not defined: the err port and its logic are absent; illegal inputs are silently ignored.

Test Plan:
- Reset held 2 cycles, then released, no coins -> out1=0, out2=0, state IDLE throughout.
- d1 pulse, then d2 pulse -> out1=1, out2=0 for one cycle after the d2 edge; return to IDLE.
- d1, d1, d3 pulses -> no output after the two d1 pulses (credit ONE); after d3, out1=1, out2=3.
- Single d3 pulse from IDLE -> out1=1, out2=1. Then d1 followed by d3 -> out1=1, out2=2.
- d2, d2 pulses -> out1=1, out2=1. Reset asserted after a lone d2 (credit ONE), then d1 -> no dispense; state HALF.
- d1 and d2 high together -> no state change, no out1. With SELLER1_ERR_EN defined, err=1 for exactly one cycle.
